// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction register and one-entry prefetch buffer for the 8-bit accumulator CPU.
//   i_clk, i_rst         clock (rising edge), synchronous active-high reset
//   i_irload             load IR from the prefetch buffer (NOP and sticky miss flag if the buffer is empty)
//   i_pcload, i_jmpmux   update PC: sequential (jmpmux=0) or jump (jmpmux=1)
//   i_jsel               01 relative jump, 10 absolute jump, other = no jump
//   i_halt               freeze PC, IR, buffer and prefetch (an outstanding read may still complete)
//   i_mem_rdata/ready    instruction word and read completion
//   o_mem_req/addr       level read request, address stable while requesting
//   o_ir158, o_ir_operand  IR opcode and operand bytes
//   o_pc                 program counter
//   o_fetch_miss         sticky: IR load attempted with an empty buffer
module fetch_unit #(
    parameter int          ADDR_W   = 6,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_irload,
    input  logic              i_pcload,
    input  logic              i_jmpmux,
    input  logic [1:0]        i_jsel,
    input  logic              i_halt,
    input  logic [15:0]       i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_ir158,
    output logic [7:0]        o_ir_operand,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_fetch_miss
);
    typedef enum logic [1:0] {PF_IDLE, PF_WAIT, PF_FULL, PF_DROP} pf_state_t;
    pf_state_t         r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, r_mem_addr, w_pc_next, w_rel, w_abs;
    logic [15:0]       r_ir, r_buf;
    logic              r_fetch_miss;
    logic              w_buf_valid, w_load, w_miss, w_jump, w_seq;
    logic [ADDR_W+7:0] w_sext, w_zext;
    assign w_buf_valid = r_state == PF_FULL;
    assign w_load      = i_irload & ~i_halt;
    assign w_miss      = w_load & ~w_buf_valid;
    // A miss swallows any PC command issued alongside it so the CU can simply retry.
    assign w_jump = ~i_halt & ~w_miss & i_pcload & i_jmpmux & (i_jsel == 2'b01 || i_jsel == 2'b10);
    assign w_seq  = ~i_halt & ~w_miss & (w_load | (i_pcload & ~i_jmpmux));
    assign w_sext = {{ADDR_W{r_ir[7]}}, r_ir[7:0]};
    assign w_zext = {{ADDR_W{1'b0}}, r_ir[7:0]};
    assign w_rel  = r_pc + w_sext[ADDR_W-1:0];
    assign w_abs  = w_zext[ADDR_W-1:0];
    always_comb begin
        w_pc_next = w_jump ? (i_jsel == 2'b01 ? w_rel : w_abs) : w_seq ? r_pc + ADDR_W'(1) : r_pc;
    end
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PF_IDLE: w_state_next = i_halt ? PF_IDLE : PF_WAIT;
            PF_WAIT: w_state_next = w_jump ? (i_mem_ready ? PF_IDLE : PF_DROP) : (i_mem_ready ? PF_FULL : PF_WAIT);
            PF_FULL: w_state_next = (w_load | w_jump) ? PF_IDLE : PF_FULL;
            PF_DROP: w_state_next = i_mem_ready ? PF_IDLE : PF_DROP;
            default: w_state_next = PF_IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= PF_IDLE;
            r_pc         <= '0;
            r_ir         <= NOP_WORD;
            r_buf        <= '0;
            r_mem_addr   <= '0;
            r_fetch_miss <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_fetch_miss <= r_fetch_miss | w_miss;
            if (w_load)
                r_ir <= w_buf_valid ? r_buf : NOP_WORD;
            if (r_state == PF_WAIT && w_state_next == PF_FULL)
                r_buf <= i_mem_rdata;
            // Issue from the PC being written this edge so a same-cycle PC update is never fetched stale.
            if (r_state == PF_IDLE && !i_halt)
                r_mem_addr <= w_pc_next;
        end
    end
    assign o_mem_req    = r_state == PF_WAIT || r_state == PF_DROP;
    assign o_mem_addr   = r_mem_addr;
    assign o_ir158      = r_ir[15:8];
    assign o_ir_operand = r_ir[7:0];
    assign o_pc         = r_pc;
    assign o_fetch_miss = r_fetch_miss;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-configurable program memory.
module tb_fetch_unit;
    logic        clk = 0, rst = 1;
    logic        irload = 0, pcload = 0, jmpmux = 0, halt = 0;
    logic [1:0]  jsel = 0;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req, fetch_miss;
    logic [5:0]  mem_addr, pc;
    logic [7:0]  ir158, ir_operand;
    logic [15:0] mem [64];
    int          lat = 0, cnt = 0;
    logic        stale_en = 0;
    int          tests = 0, fails = 0;
    typedef struct {string name; int sel; logic [15:0] exp;} chk_t;
    chk_t sb[$];
    chk_t c;
    logic [15:0] act;

    fetch_unit #(.ADDR_W(6), .NOP_WORD(16'h0000)) dut (
        .i_clk(clk), .i_rst(rst), .i_irload(irload), .i_pcload(pcload), .i_jmpmux(jmpmux),
        .i_jsel(jsel), .i_halt(halt), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_ir158(ir158), .o_ir_operand(ir_operand),
        .o_pc(pc), .o_fetch_miss(fetch_miss));

    always #5 clk = ~clk;

    initial begin
        mem_ready = 0;
        mem_rdata = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req && cnt >= lat) begin
                mem_ready = 1;
                mem_rdata = stale_en ? 16'hDEAD : mem[mem_addr];
                cnt = 0;
            end else begin
                mem_ready = 0;
                cnt = mem_req ? cnt + 1 : 0;
            end
        end
    end

    function automatic logic [15:0] actual(int sel);
        case (sel)
            0: return 16'(pc);
            1: return {ir158, ir_operand};
            2: return 16'(fetch_miss);
            3: return 16'(mem_req);
            default: return 16'(mem_addr);
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        while (sb.size() > 0) begin
            c = sb.pop_front();
            act = actual(c.sel);
            tests++;
            if (act !== c.exp) begin
                fails++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_val(string name, int sel, logic [15:0] v);
        sb.push_back('{name, sel, v});
    endtask

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_ctl();
        irload = 0; pcload = 0; jmpmux = 0; jsel = 0; halt = 0;
    endtask

    task automatic do_reset();
        idle_ctl();
        rst = 1;
        cyc(2);
        rst = 0;
    endtask

    task automatic wait_fill(string name);
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req && mem_ready) begin got = 1; break; end
        end
        @(posedge clk);
        #1;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s: got no read completion, expected one within 50 cycles", name);
        end
    endtask

    task automatic jump(logic [1:0] sel);
        pcload = 1; jmpmux = 1; jsel = sel;
        cyc();
        idle_ctl();
    endtask

    task automatic load_ir();
        irload = 1;
        cyc();
        irload = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        // reset values
        rst = 1;
        cyc(2);
        expect_val("rst_pc", 0, 16'h0000);
        expect_val("rst_ir", 1, 16'h0000);
        expect_val("rst_req", 3, 16'h0000);
        expect_val("rst_addr", 4, 16'h0000);
        expect_val("rst_miss", 2, 16'h0000);
        // 1: zero-wait memory, IRload every third cycle
        mem[0] = 16'h1005; mem[1] = 16'h2006;
        lat = 0;
        do_reset();
        cyc(2);
        load_ir();
        expect_val("t1_ir0", 1, 16'h1005);
        expect_val("t1_pc0", 0, 16'h0001);
        expect_val("t1_miss0", 2, 16'h0000);
        cyc(2);
        load_ir();
        expect_val("t1_ir1", 1, 16'h2006);
        expect_val("t1_pc1", 0, 16'h0002);
        expect_val("t1_miss1", 2, 16'h0000);
        // 2: slow memory, IRload before data returns
        lat = 4;
        do_reset();
        cyc();
        irload = 1; pcload = 1;
        cyc();
        idle_ctl();
        expect_val("t2_miss_ir", 1, 16'h0000);
        expect_val("t2_miss_pc", 0, 16'h0000);
        expect_val("t2_miss", 2, 16'h0001);
        expect_val("t2_req_held", 3, 16'h0001);
        wait_fill("t2_fill");
        load_ir();
        expect_val("t2_ir", 1, 16'h1005);
        expect_val("t2_pc", 0, 16'h0001);
        expect_val("t2_miss_sticky", 2, 16'h0001);
        // 3: absolute and relative jumps
        mem[0] = 16'h0004; mem[4] = 16'h00FE; mem[3] = 16'h002A;
        mem[42] = 16'h4242; mem[43] = 16'h4343;
        lat = 0;
        do_reset();
        wait_fill("t3_f0");
        load_ir();
        wait_fill("t3_f1");
        jump(2'b10);
        expect_val("t3_abs4", 0, 16'h0004);
        wait_fill("t3_f4");
        load_ir();
        expect_val("t3_pc5", 0, 16'h0005);
        expect_val("t3_ir_fe", 1, 16'h00FE);
        wait_fill("t3_f5");
        jump(2'b01);
        expect_val("t3_rel", 0, 16'h0003);
        wait_fill("t3_f3");
        load_ir();
        expect_val("t3_ir_2a", 1, 16'h002A);
        wait_fill("t3_f4b");
        jump(2'b10);
        expect_val("t3_abs2a", 0, 16'h002A);
        wait_fill("t3_f42");
        jump(2'b00);
        expect_val("t3_jsel00_pc", 0, 16'h002A);
        load_ir();
        expect_val("t3_noflush_ir", 1, 16'h4242);
        expect_val("t3_noflush_pc", 0, 16'h002B);
        wait_fill("t3_f43");
        irload = 1; pcload = 1;
        cyc();
        idle_ctl();
        expect_val("t3_one_inc_pc", 0, 16'h002C);
        expect_val("t3_one_inc_ir", 1, 16'h4343);
        // 4: jump while a read is outstanding, stale data discarded
        mem[0] = 16'h0010; mem[16] = 16'h5A5A;
        lat = 0;
        do_reset();
        wait_fill("t4_f0");
        load_ir();
        lat = 3;
        cyc();
        jump(2'b10);
        lat = 0; stale_en = 1;
        expect_val("t4_pc", 0, 16'h0010);
        expect_val("t4_drop_req", 3, 16'h0001);
        cyc();
        stale_en = 0;
        expect_val("t4_dropped", 3, 16'h0000);
        cyc();
        expect_val("t4_addr", 4, 16'h0010);
        expect_val("t4_req", 3, 16'h0001);
        wait_fill("t4_f16");
        load_ir();
        expect_val("t4_ir", 1, 16'h5A5A);
        expect_val("t4_pc17", 0, 16'h0011);
        // 5: PC wrap on increment and on relative jump
        mem[0] = 16'h003F; mem[63] = 16'h0080;
        do_reset();
        wait_fill("t5_f0");
        load_ir();
        wait_fill("t5_f1");
        jump(2'b10);
        expect_val("t5_pc63", 0, 16'h003F);
        wait_fill("t5_f63");
        load_ir();
        expect_val("t5_wrap", 0, 16'h0000);
        wait_fill("t5_f0b");
        pcload = 1;
        cyc();
        idle_ctl();
        expect_val("t5_seq", 0, 16'h0001);
        jump(2'b01);
        expect_val("t5_rel_wrap", 0, 16'h0001);
        // 6: halt freezes, reset during an outstanding read
        halt = 1; irload = 1; pcload = 1;
        cyc(2);
        expect_val("t6_halt_pc", 0, 16'h0001);
        expect_val("t6_halt_ir", 1, 16'h0080);
        expect_val("t6_halt_req", 3, 16'h0000);
        expect_val("t6_halt_miss", 2, 16'h0000);
        idle_ctl();
        lat = 5;
        cyc();
        expect_val("t6_wait_req", 3, 16'h0001);
        rst = 1;
        cyc();
        expect_val("t6_rst_req", 3, 16'h0000);
        expect_val("t6_rst_pc", 0, 16'h0000);
        expect_val("t6_rst_ir", 1, 16'h0000);
        expect_val("t6_rst_addr", 4, 16'h0000);
        rst = 0;
        cyc(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
